// File: rtl/router_oport_fwd.sv
// router_oport_fwd
// Forwarding stage for one output port of the 4x4 router. It sits directly
// behind that output's fixed-priority arbiter. On a grant it locks onto the
// winning input. It then forwards that input's serial frame/valid/data with
// exactly one cycle of registered latency. The connection is released at end
// of packet or when the source stalls for too long.
//
// Ports:
//   clk        clock, all state changes on the rising edge
//   reset_n    asynchronous active-low reset
//   i_gnt      grant for this output from its arbiter (expected one-hot)
//   i_frame    frame of every input port
//   i_valid    valid of every input port
//   i_data     serial data of every input port
//   o_busy     high while a connection is held
//   o_src      index of the locked source, held after release
//   o_release  one-cycle pulse when a connection ends (normal or abort)
//   o_frame    forwarded frame
//   o_valid    forwarded valid
//   o_data     forwarded data, forced 0 when o_valid is 0
//   o_bit_cnt  valid bits forwarded in the current/last packet (saturating)
//   o_err      one-cycle pulse on a protocol error
module router_oport_fwd #(
    parameter int NUM_IN  = 4,
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 64
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NUM_IN-1:0]         i_gnt,
    input  logic [NUM_IN-1:0]         i_frame,
    input  logic [NUM_IN-1:0]         i_valid,
    input  logic [NUM_IN-1:0]         i_data,
    output logic                      o_busy,
    output logic [$clog2(NUM_IN)-1:0] o_src,
    output logic                      o_release,
    output logic                      o_frame,
    output logic                      o_valid,
    output logic                      o_data,
    output logic [CNT_W-1:0]          o_bit_cnt,
    output logic                      o_err
);

    localparam int SRC_W = $clog2(NUM_IN);
    localparam int TO_W  = $clog2(TIMEOUT);
    localparam logic [TO_W-1:0]   TO_MAX  = TO_W'(TIMEOUT - 1);
    localparam logic [NUM_IN-1:0] GNT_ONE = NUM_IN'(1);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t            state_q;
    logic [SRC_W-1:0]  src_q;
    logic [TO_W-1:0]   to_cnt_q;
    logic [SRC_W-1:0]  gnt_sel;
    logic              gnt_multi;
    logic              fwd_frame;
    logic              fwd_valid;
    logic              fwd_data;

    // Pick the lowest set grant bit. A malformed multi-hot grant still
    // resolves to a usable source, and we only flag it as an error.
    // x & (x-1) clears the lowest set bit, so any bit left over means more
    // than one grant bit was set.
    always_comb begin
        gnt_sel = '0;
        for (int i = NUM_IN - 1; i >= 0; i--) begin
            if (i_gnt[i]) begin
                gnt_sel = SRC_W'(i);
            end
        end
        gnt_multi = |(i_gnt & (i_gnt - GNT_ONE));
    end

    // The locked source's signals are muxed out once here. The BUSY branch
    // below then reads like the single-source forwarding path it really is.
    always_comb begin
        fwd_frame = i_frame[src_q];
        fwd_valid = i_valid[src_q];
        fwd_data  = i_data[src_q];
    end

    // Connection FSM plus all registered outputs. The release and error
    // pulses default low every cycle, so they can never be held. In BUSY,
    // end of packet is checked before the stall timeout. A frame drop always
    // ends the packet normally, even if valid was also low in that cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            src_q     <= '0;
            to_cnt_q  <= '0;
            o_release <= 1'b0;
            o_frame   <= 1'b0;
            o_valid   <= 1'b0;
            o_data    <= 1'b0;
            o_bit_cnt <= '0;
            o_err     <= 1'b0;
        end else begin
            o_release <= 1'b0;
            o_err     <= 1'b0;
            case (state_q)
                IDLE: begin
                    o_frame <= 1'b0;
                    o_valid <= 1'b0;
                    o_data  <= 1'b0;
                    if (|i_gnt) begin
                        if (!i_frame[gnt_sel]) begin
                            o_err <= 1'b1;
                        end else begin
                            state_q   <= BUSY;
                            src_q     <= gnt_sel;
                            to_cnt_q  <= '0;
                            o_bit_cnt <= CNT_W'(i_valid[gnt_sel]);
                            o_frame   <= 1'b1;
                            o_valid   <= i_valid[gnt_sel];
                            o_data    <= i_data[gnt_sel] & i_valid[gnt_sel];
                            o_err     <= gnt_multi;
                        end
                    end
                end
                BUSY: begin
                    o_frame <= fwd_frame;
                    o_valid <= fwd_valid;
                    o_data  <= fwd_data & fwd_valid;
                    if (fwd_valid && (o_bit_cnt != '1)) begin
                        o_bit_cnt <= o_bit_cnt + CNT_W'(1);
                    end
                    if (!fwd_frame) begin
                        state_q   <= IDLE;
                        o_release <= 1'b1;
                    end else if (fwd_valid) begin
                        to_cnt_q <= '0;
                    end else if (to_cnt_q == TO_MAX) begin
                        state_q   <= IDLE;
                        o_frame   <= 1'b0;
                        o_valid   <= 1'b0;
                        o_data    <= 1'b0;
                        o_release <= 1'b1;
                        o_err     <= 1'b1;
                    end else begin
                        to_cnt_q <= to_cnt_q + TO_W'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign o_busy = (state_q == BUSY);
    assign o_src  = src_q;

endmodule
